// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NREQ requesters.
// A round-robin grant selects a requester. Its operands and select are
// registered into the ALU. After one settling cycle (EXEC), the ALU result
// is captured into a held response tagged with the requester index.
//
// Build option ALU_ARB_FIXED_PRIO_EN:
//   When defined, requester 0 always wins while it is valid.
//   Requesters 1..NREQ-1 round-robin among themselves.
//   A grant to requester 0 leaves the round-robin pointer untouched.
//
// state | meaning
// IDLE  | no op in flight, ready to accept
// EXEC  | operands registered into the ALU, result settling
// RESP  | result held on rsp_*, waiting for rsp_ready
module alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_sel,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_sel,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_carry,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_carry,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   cur_id_q, cur_id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;
  logic [2:0]       grant_sel;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Grant search: requester 0 first, then rotate over 1..NREQ-1 after last_grant
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (req_valid[0]) begin
      grant_found = 1'b1;
    end else begin
      for (int k = 1; k < NREQ; k++) begin
        int idx;
        idx = int'(last_grant_q) + k;
        // last_grant never holds 0 in this build, so wrap stays inside 1..NREQ-1
        if (idx >= NREQ) idx = idx - (NREQ - 1);
        for (int i = 1; i < NREQ; i++) begin
          if (!grant_found && (i == idx) && req_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(i);
          end
        end
      end
    end
  end
`else
  // Grant search: rotate over all requesters starting after last_grant
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(last_grant_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && (i == idx) && req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = IDW'(i);
        end
      end
    end
  end
`endif

  // Accept only when the pipeline can take a new op; never while in reset
  assign accept = !rst && grant_found &&
                  ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

  // Operand mux for the granted requester, plus one-hot ready on accept
  always_comb begin
    grant_a   = '0;
    grant_b   = '0;
    grant_sel = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(grant_idx) == i) begin
        grant_a   = req_a[i*WIDTH +: WIDTH];
        grant_b   = req_b[i*WIDTH +: WIDTH];
        grant_sel = req_sel[i*3 +: 3];
        req_ready[i] = accept;
      end
    end
  end

  // Next-state and datapath load/capture decisions
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = cur_id_q;
        rsp_data_d  = alu_out;
        rsp_carry_d = alu_carry;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    if (accept) begin
      alu_a_d   = grant_a;
      alu_b_d   = grant_b;
      alu_sel_d = grant_sel;
      cur_id_d  = grant_idx;
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (grant_idx != '0) last_grant_d = grant_idx;
`else
      last_grant_d = grant_idx;
`endif
    end
  end

  // State and datapath registers; reset discards any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      cur_id_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model (add / sub / and).
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 3;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_sel;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [2:0]        alu_sel;
  logic [W-1:0]      alu_out;
  logic              alu_carry;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_carry;
  logic              busy;

  int checks;
  int failures;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: 000 add with carry, 001 subtract with borrow, else AND
  always_comb begin
    case (alu_sel)
      3'b000:  {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      default: {alu_carry, alu_out} = {1'b0, alu_a & alu_b};
    endcase
  end

  function automatic logic [W-1:0] opa(int i);
    return 16'h9000 + 16'(i);
  endfunction

  function automatic logic [W-1:0] opb(int i);
    return 16'h8000 + 16'(i * 256);
  endfunction

  function automatic logic [2:0] opsel(int i);
    return (i == 1) ? 3'b001 : 3'b000;
  endfunction

  // Expected {carry, data} for requester i's standard operands
  function automatic logic [W:0] expres(int i);
    if (opsel(i) == 3'b001) return {1'b0, opa(i)} - {1'b0, opb(i)};
    return {1'b0, opa(i)} + {1'b0, opb(i)};
  endfunction

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = opa(i);
      req_b[i*W +: W] = opb(i);
      req_sel[i*3 +: 3] = opsel(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [W:0] er;
  int order [5];

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    set_ops();
    tick();
    tick();

    // While reset is held, nothing is accepted or reported
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);

`ifdef ALU_ARB_FIXED_PRIO_EN
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    #1;
    for (int n = 0; n < 3; n++) begin
      chk("fp_ready0", 32'(req_ready), 32'h1);
      tick();
      tick();
      chk("fp_id0", 32'(rsp_id), 32'h0);
    end
    req_valid = 4'b0010;
    #1;
    chk("fp_ready1", 32'(req_ready), 32'h2);
    tick();
    tick();
    chk("fp_id1", 32'(rsp_id), 32'h1);
    req_valid = 4'b1111;
    #1;
    chk("fp_ready0_again", 32'(req_ready), 32'h1);
    tick();
    tick();
    chk("fp_id0_again", 32'(rsp_id), 32'h0);
    // Grant to 0 left the pointer at 1, so 2 is next among 1..3
    req_valid = 4'b1110;
    #1;
    chk("fp_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("fp_id2", 32'(rsp_id), 32'h2);
    tick();
    chk("fp_idle", 32'(rsp_valid), 32'h0);
`else
    // Single op from requester 2
    rst = 1'b0;
    req_valid = 4'b0100;
    req_a[2*W +: W] = 16'hE03F;
    req_b[2*W +: W] = 16'h7F80;
    req_sel[2*3 +: 3] = 3'b000;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_busy_idle", 32'(busy), 32'h0);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("exec_busy", 32'(busy), 32'h1);
    chk("exec_alu_a", 32'(alu_a), 32'hE03F);
    chk("exec_alu_b", 32'(alu_b), 32'h7F80);
    chk("exec_alu_sel", 32'(alu_sel), 32'h0);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("exec_req_ready", 32'(req_ready), 32'h0);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_id", 32'(rsp_id), 32'h2);
    chk("single_rsp_data", 32'(rsp_data), 32'h5FBF);
    chk("single_rsp_carry", 32'(rsp_carry), 32'h1);

    // Backpressure: response held, requester 0 waits
    set_ops();
    req_valid = 4'b0001;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h5FBF);
      chk("bp_rsp_id", 32'(rsp_id), 32'h2);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("bp_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("bp_exec_alu_a", 32'(alu_a), 32'(opa(0)));
    tick();
    er = expres(0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_rsp_id0", 32'(rsp_id), 32'h0);
    chk("bp_rsp_data0", 32'(rsp_data), 32'(er[W-1:0]));
    chk("bp_rsp_carry0", 32'(rsp_carry), 32'(er[W]));
    tick();
    chk("bp_to_idle_valid", 32'(rsp_valid), 32'h0);
    chk("bp_to_idle_busy", 32'(busy), 32'h0);

    // Round-robin with all four valid, one accept every two cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    order = '{0, 1, 2, 3, 0};
    for (int n = 0; n < 5; n++) begin
      chk("rr_ready", 32'(req_ready), 32'h1 << order[n]);
      tick();
      chk("rr_exec_busy", 32'(busy), 32'h1);
      chk("rr_exec_ready", 32'(req_ready), 32'h0);
      chk("rr_exec_sel", 32'(alu_sel), 32'(opsel(order[n])));
      tick();
      er = expres(order[n]);
      chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("rr_rsp_id", 32'(rsp_id), 32'(order[n]));
      chk("rr_rsp_data", 32'(rsp_data), 32'(er[W-1:0]));
      chk("rr_rsp_carry", 32'(rsp_carry), 32'(er[W]));
    end

    // Reset during EXEC of the requester 1 op
    chk("mid_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("mid_exec_alu_a", 32'(alu_a), 32'(opa(1)));
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'h0);
    req_valid = 4'b1001;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(req_ready), 32'h1);
    tick();
    tick();
    chk("post_rst_id0", 32'(rsp_id), 32'h0);
    chk("post_rst_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("post_rst_id3", 32'(rsp_id), 32'h3);
    tick();
    chk("post_rst_idle", 32'(rsp_valid), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
